// File: rtl/mddr_axi_tester.sv
// AXI4 master traffic generator and checker for PL DDR3.
// Each pass writes an address-derived pattern over NUM_BURSTS bursts of
// BURST_LEN beats, then reads everything back and compares beat by beat.
// Ports:
//   aclk, aresetn                 clock, async active-low reset
//   start, loop_en, calib_done    run control and MIG calibration status
//   m_axi_aw*/w*/b*/ar*/r*        AXI4 master (one outstanding transaction)
//   busy, done, error             run status (error is sticky)
//   err_cnt, pass_cnt             saturating error count, wrapping pass count
module mddr_axi_tester #(
    parameter int unsigned DATA_W     = 64,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned NUM_BURSTS = 1024,
    parameter int unsigned BURST_LEN  = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic                  loop_en,
    input  logic                  calib_done,
    output logic [31:0]           m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [31:0]           m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           err_cnt,
    output logic [15:0]           pass_cnt
);

    localparam int unsigned BYTES       = DATA_W / 8;
    localparam int unsigned LANES       = DATA_W / 32;
    localparam int unsigned IDX_W       = 16;
    localparam int unsigned BEAT_W      = 8;
    localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * BYTES);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BURSTS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [2:0]  AXI_SIZE    = 3'($clog2(BYTES));
    localparam logic [1:0]  AXI_INCR    = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [15:0]           pass_q, pass_d;
    logic [15:0]           err_cnt_q, err_cnt_d;
    logic                  error_q, error_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_hit;
    logic                  awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q;
    logic [31:0]           awaddr_q, awaddr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;

    // Byte address of a beat within the test region.
    function automatic logic [31:0] beat_addr(input logic [IDX_W-1:0] idx,
                                              input logic [BEAT_W-1:0] beat);
        return BASE_ADDR + 32'(idx) * BURST_BYTES + 32'(beat) * 32'(BYTES);
    endfunction

    // Address-derived test pattern, keyed by the pass number.
    function automatic logic [DATA_W-1:0] pattern(input logic [31:0] addr,
                                                  input logic [15:0] pass);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            d[32*i +: 32] = (addr + 32'(4 * i)) ^ {pass, 16'h5A5A};
        end
        return d;
    endfunction

    // Next-state and status logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        beat_d    = beat_q;
        pass_d    = pass_q;
        err_cnt_d = err_cnt_q;
        error_d   = error_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_hit   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && calib_done) begin
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    err_cnt_d = '0;
                    pass_d    = '0;
                    busy_d    = 1'b1;
                    idx_d     = '0;
                    beat_d    = '0;
                    state_d   = S_WR_ADDR;
                end
            end
            S_WR_ADDR: begin
                if (m_axi_awready) begin
                    beat_d  = '0;
                    state_d = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (m_axi_wready) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_WR_RESP;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            S_WR_RESP: begin
                if (m_axi_bvalid) begin
                    err_hit = (m_axi_bresp != 2'b00);
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_RD_ADDR;
                    end else begin
                        idx_d   = idx_q + 16'd1;
                        state_d = S_WR_ADDR;
                    end
                end
            end
            S_RD_ADDR: begin
                if (m_axi_arready) begin
                    beat_d  = '0;
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (m_axi_rvalid) begin
                    // Any combination of faults on one beat counts once.
                    err_hit = (m_axi_rdata != pattern(beat_addr(idx_q, beat_q), pass_q))
                            || (m_axi_rresp != 2'b00)
                            || (m_axi_rlast != (beat_q == LAST_BEAT));
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        if (idx_q == LAST_IDX) begin
                            pass_d = pass_q + 16'd1;
                            idx_d  = '0;
                            if (loop_en && start) begin
                                state_d = S_WR_ADDR;
                            end else begin
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                state_d = S_DONE;
                            end
                        end else begin
                            idx_d   = idx_q + 16'd1;
                            state_d = S_RD_ADDR;
                        end
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (err_hit) begin
            error_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    // Payloads track the next beat so they are stable while a valid waits.
    assign awaddr_d = beat_addr(idx_d, '0);
    assign wdata_d  = pattern(beat_addr(idx_d, beat_d), pass_d);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            beat_q    <= '0;
            pass_q    <= '0;
            err_cnt_q <= '0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            beat_q    <= beat_d;
            pass_q    <= pass_d;
            err_cnt_q <= err_cnt_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            awvalid_q <= (state_d == S_WR_ADDR);
            wvalid_q  <= (state_d == S_WR_DATA);
            wlast_q   <= (state_d == S_WR_DATA) && (beat_d == LAST_BEAT);
            bready_q  <= (state_d == S_WR_RESP);
            arvalid_q <= (state_d == S_RD_ADDR);
            rready_q  <= (state_d == S_RD_DATA);
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = LAST_BEAT;
    assign m_axi_awsize  = AXI_SIZE;
    assign m_axi_awburst = AXI_INCR;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = wlast_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = awaddr_q;
    assign m_axi_arlen   = LAST_BEAT;
    assign m_axi_arsize  = AXI_SIZE;
    assign m_axi_arburst = AXI_INCR;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_cnt       = err_cnt_q;
    assign pass_cnt      = pass_q;

endmodule

// File: tb/tb_mddr_axi_tester.sv
// Bench for mddr_axi_tester: AXI slave memory with optional random stalls
// and fault injection, a reference model feeding per-channel scoreboards,
// and a monitor that checks every handshake and payload stability.
module tb_mddr_axi_tester;

    localparam int unsigned DW = 64;
    localparam int unsigned NB = 4;
    localparam int unsigned BL = 16;

    logic          aclk, aresetn, start, loop_en, calib_done;
    logic [31:0]   awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic          busy, done, error;
    logic [15:0]   err_cnt, pass_cnt;

    mddr_axi_tester #(.DATA_W(DW), .BASE_ADDR(32'h0), .NUM_BURSTS(NB), .BURST_LEN(BL)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .loop_en(loop_en), .calib_done(calib_done),
        .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
        .m_axi_rready(rready), .busy(busy), .done(done), .error(error),
        .err_cnt(err_cnt), .pass_cnt(pass_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic extra(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=unexpected-handshake required=none t=%0t", name, $time);
    endtask

    // Scoreboards filled by the reference model.
    logic [31:0] exp_aw[$];
    logic [64:0] exp_w[$];
    logic [31:0] exp_ar[$];

    function automatic logic [63:0] ref_beat(input logic [31:0] a, input int p);
        logic [31:0] key;
        key = {16'(p), 16'h5A5A};
        return {(a + 32'd4) ^ key, a ^ key};
    endfunction

    task automatic push_pass(input int p);
        logic [31:0] a;
        for (int k = 0; k < int'(NB); k++) begin
            a = 32'(k * int'(BL) * 8);
            exp_aw.push_back(a);
            exp_ar.push_back(a);
            for (int j = 0; j < int'(BL); j++)
                exp_w.push_back({(j == int'(BL) - 1), ref_beat(a + 32'(j * 8), p)});
        end
    endtask

    // Slave state and fault injection knobs.
    logic [63:0] mem [logic [31:0]];
    bit          stall_en = 0;
    logic [31:0] flip_addr = 32'hFFFF_FFF0;
    int          slverr_burst = -1;
    bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    int          b_pend, aw_cnt, wbeat, r_beat;
    bit          b_err_q[$];
    logic [31:0] ar_q[$];
    logic [31:0] cur_waddr, r_addr;
    bit          r_active;

    function automatic int rnd();
        return stall_en ? int'($urandom_range(0, 5)) : 0;
    endfunction

    // Monitor: observes handshakes half a cycle before the capturing edge.
    bit          aw_st, w_st, ar_st;
    logic [31:0] aw_hold, ar_hold;
    logic [64:0] w_hold;
    initial begin
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                aw_st = 0; w_st = 0; ar_st = 0;
                continue;
            end
            if (aw_st) chk("aw_stable", {awvalid, awaddr}, {1'b1, aw_hold});
            if (w_st)  chk("w_stable", {wvalid, wlast, wdata}, {1'b1, w_hold});
            if (ar_st) chk("ar_stable", {arvalid, araddr}, {1'b1, ar_hold});
            aw_st = awvalid && !awready; aw_hold = awaddr;
            w_st  = wvalid && !wready;   w_hold  = {wlast, wdata};
            ar_st = arvalid && !arready; ar_hold = araddr;
            if (awvalid && awready) begin
                if (exp_aw.size() == 0) extra("aw_extra");
                else chk("aw_addr", awaddr, exp_aw.pop_front());
                chk("awlen", awlen, 15);
                cur_waddr = awaddr;
                wbeat = 0;
                b_err_q.push_back(aw_cnt == slverr_burst);
                aw_cnt = (aw_cnt + 1) % int'(NB);
                aw_hs = 1;
            end
            if (wvalid && wready) begin
                if (exp_w.size() == 0) extra("w_extra");
                else chk("w_beat", {wlast, wdata}, exp_w.pop_front());
                mem[cur_waddr + 32'(wbeat * 8)] = wdata;
                if (wbeat == int'(BL) - 1) b_pend++;
                wbeat++;
                w_hs = 1;
            end
            if (bvalid && bready) b_hs = 1;
            if (arvalid && arready) begin
                if (exp_ar.size() == 0) extra("ar_extra");
                else chk("ar_addr", araddr, exp_ar.pop_front());
                chk("arlen", arlen, 15);
                ar_q.push_back(araddr);
                ar_hs = 1;
            end
            if (rvalid && rready) r_hs = 1;
        end
    end

    // Slave drivers: update just after each rising edge.
    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = '0; rresp = 0; rlast = 0;
        forever begin
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
                aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
                b_pend = 0; aw_cnt = 0; r_active = 0;
                b_err_q.delete(); ar_q.delete();
                continue;
            end
            if (aw_hs) begin awready = 0; aw_hs = 0; aw_wait = rnd(); end
            if (awvalid && !awready) begin
                if (aw_wait == 0) awready = 1; else aw_wait--;
            end
            if (w_hs) begin wready = 0; w_hs = 0; w_wait = rnd(); end
            if (wvalid && !wready) begin
                if (w_wait == 0) wready = 1; else w_wait--;
            end
            if (b_hs) begin bvalid = 0; b_hs = 0; b_wait = rnd(); end
            if (!bvalid && b_pend > 0) begin
                if (b_wait == 0) begin
                    bresp  = (b_err_q.size() > 0 && b_err_q.pop_front()) ? 2'b10 : 2'b00;
                    bvalid = 1;
                    b_pend--;
                end else b_wait--;
            end
            if (ar_hs) begin arready = 0; ar_hs = 0; ar_wait = rnd(); end
            if (arvalid && !arready) begin
                if (ar_wait == 0) arready = 1; else ar_wait--;
            end
            if (r_hs) begin
                rvalid = 0; r_hs = 0; r_beat++; r_wait = rnd();
                if (r_beat == int'(BL)) r_active = 0;
            end
            if (!r_active && ar_q.size() > 0) begin
                r_addr = ar_q.pop_front(); r_active = 1; r_beat = 0;
            end
            if (r_active && !rvalid) begin
                if (r_wait == 0) begin
                    logic [31:0] a;
                    logic [63:0] d;
                    a = r_addr + 32'(r_beat * 8);
                    d = mem.exists(a) ? mem[a] : 64'h0;
                    if (a == flip_addr) d[3] = ~d[3];
                    rdata = d; rresp = 2'b00; rlast = (r_beat == int'(BL) - 1); rvalid = 1;
                end else r_wait--;
            end
        end
    end

    // Runs one scenario from IDLE and checks the final status.
    task automatic run_scn(input string tag, input int npass, input int exp_err, input bit loop);
        int n;
        for (int p = 0; p < npass; p++) push_pass(p);
        calib_done = 1; loop_en = loop;
        @(posedge aclk); #1 start = 1;
        n = 0;
        while (busy !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        chk({tag, "_busy_rise"}, busy, 1);
        chk({tag, "_done_clr"}, done, 0);
        if (loop) begin
            n = 0;
            while (pass_cnt !== 16'(npass - 1) && n < 20000) begin @(negedge aclk); n++; end
            chk({tag, "_loop_reach"}, pass_cnt, npass - 1);
            chk({tag, "_loop_nodone"}, done, 0);
            @(posedge aclk); #1 start = 0;
        end
        n = 0;
        while (done !== 1'b1 && n < 20000) begin @(negedge aclk); n++; end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_pass_cnt"}, pass_cnt, npass);
        chk({tag, "_err_cnt"}, err_cnt, exp_err);
        chk({tag, "_error"}, error, exp_err != 0);
        chk({tag, "_sb_empty"}, exp_aw.size() + exp_w.size() + exp_ar.size(), 0);
        @(posedge aclk); #1 start = 0;
        repeat (3) @(negedge aclk);
        chk({tag, "_done_hold"}, {done, busy}, 2'b10);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit bad;
        aresetn = 0; start = 0; loop_en = 0; calib_done = 0;
        repeat (3) @(posedge aclk);
        #2;
        chk("rst_ctrl", {awvalid, wvalid, bready, arvalid, rready, busy, done, error}, 8'h00);
        chk("rst_cnts", {err_cnt, pass_cnt}, 32'h0);
        chk("rst_len", {awlen, arlen}, 16'h0F0F);
        chk("rst_size_burst", {awsize, arsize, awburst, arburst}, {3'd3, 3'd3, 2'b01, 2'b01});
        chk("rst_wstrb", wstrb, 8'hFF);
        @(posedge aclk); #3 aresetn = 1;

        run_scn("s1", 1, 0, 0);
        stall_en = 1;
        run_scn("s2", 1, 0, 0);
        stall_en = 0; flip_addr = 32'h88;
        run_scn("s3", 1, 1, 0);
        flip_addr = 32'hFFFF_FFF0; slverr_burst = 2;
        run_scn("s4", 1, 1, 0);
        slverr_burst = -1;
        run_scn("s5", 3, 0, 1);

        // No calibration: start must be ignored.
        calib_done = 0; loop_en = 0;
        @(posedge aclk); #1 start = 1;
        bad = 0;
        repeat (100) begin
            @(negedge aclk);
            if (awvalid || wvalid || arvalid || busy) bad = 1;
        end
        chk("nocal_idle", {bad, busy}, 2'b00);

        // Abort mid write data with an asynchronous reset.
        push_pass(0);
        calib_done = 1;
        n = 0;
        while (wvalid !== 1'b1 && n < 100) begin @(negedge aclk); n++; end
        chk("abort_reach_wdata", wvalid, 1);
        @(negedge aclk);
        #2 aresetn = 0;
        #1;
        chk("abort_async", {wvalid, busy, awvalid, done}, 4'b0000);
        start = 0;
        exp_aw.delete(); exp_w.delete(); exp_ar.delete();
        repeat (2) @(posedge aclk);
        #3 aresetn = 1;
        run_scn("s6", 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
